// File: rtl/segm_scan_ctrl.sv
// -----------------------------------------------------------------------------
// segm_scan_ctrl
//
// Purpose:
//   Drives a two-digit, common-anode seven-segment display from a 4-bit
//   Gray-code input. The Gray value is synchronized, converted to binary and
//   split into tens/units. Both digits are time-multiplexed on the shared
//   segment lines with a blanking gap between them. A debounced push-button
//   toggles a hold mode that freezes the displayed value.
//
// Parameters:
//   REFRESH_CYCLES  cycles each digit stays lit (>= 1)
//   BLANK_CYCLES    cycles with both anodes off between digits (>= 1)
//   DEB_CYCLES      consecutive stable cycles to accept a new button level (>= 1)
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               synchronous, active-low reset
//   s[3:0]              Gray-code value, asynchronous to clk
//   bot                 raw push-button, active-high, bouncing
//   a,b,c,d,e,f,g       segments, active-low, registered
//   an0                 units anode, active-low, registered
//   an1                 tens anode, active-low, registered
//   led3..led0          binary value currently displayed (led3 = MSB), registered
//
// Build option:
//   SEGM_LEADING_ZERO_BLANK_EN  when defined, the tens digit slot stays dark
//                               (anode and segments off) while the tens digit
//                               is 0; scan timing is unchanged.
// -----------------------------------------------------------------------------
module segm_scan_ctrl #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter int DEB_CYCLES     = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] s,
    input  logic       bot,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       an0,
    output logic       an1,
    output logic       led3,
    output logic       led2,
    output logic       led1,
    output logic       led0
);

    // Shared dwell counter must hold the larger of the two load values.
    localparam int CNT_MAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [CNT_W-1:0] REFRESH_LOAD = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEB_CYCLES - 1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic [1:0] {
        SCAN_U  = 2'd0,
        BLANK_U = 2'd1,
        SCAN_T  = 2'd2,
        BLANK_T = 2'd3
    } scan_state_t;

    // Input synchronizers
    logic [3:0] s_meta_reg;
    logic [3:0] s_sync_reg;
    logic       bot_meta_reg;
    logic       bot_sync_reg;

    // Debounce / hold
    logic             deb_level_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             hold_reg;
    logic [3:0]       frozen_reg;

    // Scan FSM and registered outputs
    scan_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [6:0]       seg_reg;
    logic             an0_reg;
    logic             an1_reg;
    logic [3:0]       led_reg;

    // Combinational datapath
    logic [3:0] v;
    logic [3:0] dv;
    logic       tens;
    logic [3:0] units;
    logic [6:0] seg_units;
    logic [6:0] seg_tens;
    logic       tens_visible;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gray2bin
            assign v[gi] = ^s_sync_reg[3:gi];
        end
    endgenerate

    // Displayed value: the snapshot while holding, the live value otherwise.
    assign dv    = hold_reg ? frozen_reg : v;
    assign tens  = (dv >= 4'd10);
    assign units = tens ? (dv - 4'd10) : dv;

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b0000001;
            4'd1:    pat = 7'b1001111;
            4'd2:    pat = 7'b0010010;
            4'd3:    pat = 7'b0000110;
            4'd4:    pat = 7'b1001100;
            4'd5:    pat = 7'b0100100;
            4'd6:    pat = 7'b0100000;
            4'd7:    pat = 7'b0001111;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0000100;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

    assign seg_units = seg_pattern(units);
    assign seg_tens  = seg_pattern({3'b000, tens});

`ifdef SEGM_LEADING_ZERO_BLANK_EN
    assign tens_visible = tens;
`else
    assign tens_visible = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous switch and button inputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_meta_reg   <= 4'b0000;
            s_sync_reg   <= 4'b0000;
            bot_meta_reg <= 1'b0;
            bot_sync_reg <= 1'b0;
        end else begin
            s_meta_reg   <= s;
            s_sync_reg   <= s_meta_reg;
            bot_meta_reg <= bot;
            bot_sync_reg <= bot_meta_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: the accepted level flips only after the synchronized button
    // has disagreed with it for DEB_CYCLES consecutive cycles. Any agreeing
    // cycle restarts the count. A rising accepted level toggles hold, and
    // entering hold captures the value on display in that same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_level_reg <= 1'b0;
            deb_cnt_reg   <= '0;
            hold_reg      <= 1'b0;
            frozen_reg    <= 4'b0000;
        end else if (bot_sync_reg != deb_level_reg) begin
            if (deb_cnt_reg == DEB_LAST) begin
                deb_level_reg <= bot_sync_reg;
                deb_cnt_reg   <= '0;
                if (bot_sync_reg) begin
                    hold_reg <= ~hold_reg;
                    if (!hold_reg) begin
                        frozen_reg <= dv;
                    end
                end
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
        end else begin
            deb_cnt_reg <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Scan FSM with registered anode/segment/LED outputs. The outputs decode
    // the current state, so they trail the state by one cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= SCAN_U;
            cnt_reg   <= REFRESH_LOAD;
            seg_reg   <= SEG_OFF;
            an0_reg   <= 1'b1;
            an1_reg   <= 1'b1;
            led_reg   <= 4'b0000;
        end else begin
            if (cnt_reg == '0) begin
                case (state_reg)
                    SCAN_U: begin
                        state_reg <= BLANK_U;
                        cnt_reg   <= BLANK_LOAD;
                    end
                    BLANK_U: begin
                        state_reg <= SCAN_T;
                        cnt_reg   <= REFRESH_LOAD;
                    end
                    SCAN_T: begin
                        state_reg <= BLANK_T;
                        cnt_reg   <= BLANK_LOAD;
                    end
                    default: begin
                        state_reg <= SCAN_U;
                        cnt_reg   <= REFRESH_LOAD;
                    end
                endcase
            end else begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end

            case (state_reg)
                SCAN_U: begin
                    an0_reg <= 1'b0;
                    an1_reg <= 1'b1;
                    seg_reg <= seg_units;
                end
                SCAN_T: begin
                    an0_reg <= 1'b1;
                    an1_reg <= ~tens_visible;
                    seg_reg <= tens_visible ? seg_tens : SEG_OFF;
                end
                default: begin
                    an0_reg <= 1'b1;
                    an1_reg <= 1'b1;
                    seg_reg <= SEG_OFF;
                end
            endcase

            led_reg <= dv;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_reg;
    assign an0  = an0_reg;
    assign an1  = an1_reg;
    assign led3 = led_reg[3];
    assign led2 = led_reg[2];
    assign led1 = led_reg[1];
    assign led0 = led_reg[0];

endmodule

// File: doc/segm_scan_ctrl.md
# segm_scan_ctrl

Sequential controller for the two-digit seven-segment display driven by the 4-bit Gray-code input. It synchronizes the Gray input, converts it to tens/units, and time-multiplexes both digits on the shared segment lines with a blanking gap between digits. It also debounces the push-button, which toggles a hold (freeze) mode. It replaces manual digit selection and sits between the board switches/button and the display pins.

## Interface
- `REFRESH_CYCLES`, 100000: clock cycles each digit stays lit; must be ≥1.
- `BLANK_CYCLES`, 16: cycles with both anodes off between digits; must be ≥1.
- `DEB_CYCLES`, 1000000: consecutive stable cycles required to accept a new button level; must be ≥1.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `s`  in  4  Gray-code value, asynchronous to `clk`.
- `bot`  in  1  raw push-button, active-high, bouncing.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`  out  1 each  segments, active-low, registered.
- `an0`  out  1  units anode, active-low, registered.
- `an1`  out  1  tens anode, active-low, registered.
- `led3..led0`  out  1 each  binary value currently displayed; `led3` is the MSB; registered.

## Operation
- Input path: `s` and `bot` pass through 2-flop synchronizers. The synchronized Gray value is converted to binary `v` (0–15). Tens digit = (v ≥ 10). Units digit = v − 10·tens.
- Hold: the debounced button level changes only after the synchronized `bot` differs from it for `DEB_CYCLES` consecutive cycles. On each debounced 0→1 transition, `hold` toggles.
  - When `hold`=1, the displayed value `dv` stays frozen at its value on the toggle cycle.
  - When `hold`=0, `dv` follows `v` every cycle.
  - A 1→0 debounced transition has no effect.
- Scan FSM states: `SCAN_U` → `BLANK_U` → `SCAN_T` → `BLANK_T` → `SCAN_U`.
  - Shared down-counter loads `REFRESH_CYCLES`−1 on entry to a SCAN state and `BLANK_CYCLES`−1 on entry to a BLANK state.
  - The FSM advances when the counter reaches 0.
- Output decode, registered one cycle after the state:
  - `SCAN_U`: `an0`=0, `an1`=1, segments = units digit.
  - `SCAN_T`: `an0`=1, `an1`=0, segments = tens digit.
  - BLANK states: both anodes 1, all segments 1.
- Segment patterns, active-low, `abcdefg` order:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- `led3..led0` = `dv`, registered.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets:
  - FSM = `SCAN_U`; counter = `REFRESH_CYCLES`−1.
  - `hold`=0; debounced level=0; debounce count=0; synchronizers=0.
  - `an0`=`an1`=1; all segments=1; `led3..0`=0.
- Reset mid-scan or mid-debounce aborts immediately; no partial state survives.
- First cycle with `rst_n`=1: FSM in `SCAN_U`. `an0` goes to 0 at the end of that cycle, one edge after reset release.
- Input latency: a change on `s` appears on `led3..0` and in the digit content at the 3rd rising edge after the change (2 sync + 1 output register), provided `hold`=0.
- Dwell times: each SCAN state lasts exactly `REFRESH_CYCLES` cycles and each BLANK state exactly `BLANK_CYCLES` cycles. Full period = 2·(`REFRESH_CYCLES`+`BLANK_CYCLES`).
- An anode is never low while the other is low; both anodes are high for ≥`BLANK_CYCLES` between active digits.
- Value change during a SCAN state: the segments update in the same cycle as `led3..0`; the scan schedule is unaffected.
- Button press simultaneous with an `s` change: the frozen snapshot is the `dv` present on the toggle cycle.
- Debounce: a bounce shorter than `DEB_CYCLES` restarts the count and never toggles `hold`.

## Configuration
- `SEGM_LEADING_ZERO_BLANK_EN`
  - Defined: when the tens digit is 0, `SCAN_T` drives `an1`=1 and all segments=1. Timing is unchanged.
  - Undefined: the tens digit is always displayed, showing "0" for values 0–9.

## Test plan
Bench uses `REFRESH_CYCLES`=4, `BLANK_CYCLES`=2, `DEB_CYCLES`=3.
- Reset then release, `s`=0000: `an0`=0 one edge after release; units segments=0000001; after 4 cycles both anodes=1 for 2 cycles; then `an1`=0 with tens=0000001 (or blank with `SEGM_LEADING_ZERO_BLANK_EN`).
- Sweep `s` over all 16 Gray codes, one full scan period each: `led3..0` = 0..15; Gray 1111 → tens segments 1001111, units 0000001; Gray 1000 → tens 1001111, units 0100100.
- `s` 0000→1101: `led3..0`=1001 exactly 3 edges later.
- `bot` high for 3 cycles with `s`=0110, then `s`→1000: `led3..0` stays 0100. A second press resumes tracking to 1111.
- `bot` pulses of 1–2 cycles repeated 10 times: `hold` never toggles.
- Assert `rst_n`=0 during `SCAN_T` with `hold`=1: next edge gives anodes=11, segments all 1, `led`=0, `hold`=0.
